// File: rtl/apu_fpu_arbiter.sv
// Round-robin arbiter that shares one tag-extended FPU between NB_CORES APU masters.
// Routes responses back to their cores by tag and caps in-flight ops per core.
module apu_fpu_arbiter #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned APU_NARGS       = 3,
    parameter int unsigned APU_WOP         = 6,
    parameter int unsigned APU_NDSFLAGS    = 15,
    parameter int unsigned APU_NUSFLAGS    = 5,
    localparam int unsigned ID_W           = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_CORES-1:0]                           core_req_i,
    output logic [NB_CORES-1:0]                           core_gnt_o,
    input  logic [NB_CORES-1:0][APU_NARGS-1:0][31:0]      core_operands_i,
    input  logic [NB_CORES-1:0][APU_WOP-1:0]              core_op_i,
    input  logic [NB_CORES-1:0][APU_NDSFLAGS-1:0]         core_flags_i,
    output logic [NB_CORES-1:0]                           core_rvalid_o,
    output logic [31:0]                                   core_rdata_o,
    output logic [APU_NUSFLAGS-1:0]                       core_rflags_o,
    output logic                                          fpu_req_o,
    input  logic                                          fpu_gnt_i,
    output logic [APU_NARGS-1:0][31:0]                    fpu_operands_o,
    output logic [APU_WOP-1:0]                            fpu_op_o,
    output logic [APU_NDSFLAGS-1:0]                       fpu_flags_o,
    output logic [ID_W-1:0]                               fpu_tag_o,
    input  logic                                          fpu_rvalid_i,
    input  logic [31:0]                                   fpu_rdata_i,
    input  logic [APU_NUSFLAGS-1:0]                       fpu_rflags_i,
    input  logic [ID_W-1:0]                               fpu_rtag_i,
    output logic                                          busy_o,
    output logic                                          err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NB_CORES-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic [NB_CORES-1:0]             elig;
    logic [ID_W-1:0]                 winner;
    logic [ID_W-1:0]                 idx;
    logic                            any_elig;
    logic                            issue;
    logic                            rtag_oob;

    // Eligibility and round-robin winner search starting at rr_ptr
    always_comb begin
        elig     = '0;
        winner   = '0;
        idx      = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            elig[i] = core_req_i[i] && (cnt_q[i] < CNT_MAX);
        end
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % NB_CORES);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                winner   = idx;
            end
        end
    end

    assign issue = any_elig && fpu_gnt_i;

    always_comb begin
        core_gnt_o         = '0;
        core_gnt_o[winner] = issue;
    end

    assign fpu_req_o      = any_elig;
    assign fpu_tag_o      = winner;
    assign fpu_operands_o = core_operands_i[winner];
    assign fpu_op_o       = core_op_i[winner];
    assign fpu_flags_o    = core_flags_i[winner];

    // Response routing by returned tag
    assign rtag_oob = 32'(fpu_rtag_i) >= NB_CORES;

    always_comb begin
        core_rvalid_o = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            core_rvalid_o[i] = fpu_rvalid_i && (32'(fpu_rtag_i) == i);
        end
    end

    assign core_rdata_o  = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;

    // Counter, pointer and error next-state
    always_comb begin
        cnt_d    = cnt_q;
        err_d    = err_q | (fpu_rvalid_i && rtag_oob);
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = ID_W'((32'(winner) + 1) % NB_CORES);
        end
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            if (issue && (32'(winner) == i) && !core_rvalid_o[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (core_rvalid_o[i] && !(issue && (32'(winner) == i))) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign busy_o = |cnt_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_apu_fpu_arbiter.sv
// Bench for apu_fpu_arbiter: directed scenarios plus randomized traffic,
// all checked against a per-cycle behavioural model of arbitration and counters.
module tb_apu_fpu_arbiter;

    localparam int NB   = 4;
    localparam int MAXO = 4;

    logic                         clk_i;
    logic                         rst_ni;
    logic [NB-1:0]                core_req_i;
    logic [NB-1:0]                core_gnt_o;
    logic [NB-1:0][2:0][31:0]     core_operands_i;
    logic [NB-1:0][5:0]           core_op_i;
    logic [NB-1:0][14:0]          core_flags_i;
    logic [NB-1:0]                core_rvalid_o;
    logic [31:0]                  core_rdata_o;
    logic [4:0]                   core_rflags_o;
    logic                         fpu_req_o;
    logic                         fpu_gnt_i;
    logic [2:0][31:0]             fpu_operands_o;
    logic [5:0]                   fpu_op_o;
    logic [14:0]                  fpu_flags_o;
    logic [1:0]                   fpu_tag_o;
    logic                         fpu_rvalid_i;
    logic [31:0]                  fpu_rdata_i;
    logic [4:0]                   fpu_rflags_i;
    logic [1:0]                   fpu_rtag_i;
    logic                         busy_o;
    logic                         err_o;

    apu_fpu_arbiter dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operands_i (core_operands_i),
        .core_op_i       (core_op_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_rdata_o    (core_rdata_o),
        .core_rflags_o   (core_rflags_o),
        .fpu_req_o       (fpu_req_o),
        .fpu_gnt_i       (fpu_gnt_i),
        .fpu_operands_o  (fpu_operands_o),
        .fpu_op_o        (fpu_op_o),
        .fpu_flags_o     (fpu_flags_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_rvalid_i    (fpu_rvalid_i),
        .fpu_rdata_i     (fpu_rdata_i),
        .fpu_rflags_i    (fpu_rflags_i),
        .fpu_rtag_i      (fpu_rtag_i),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors;
    int miscompares;

    // Reference model state: next core to favour, in-flight count per core, sticky error
    int rr_m;
    int cnt_m [NB];
    bit err_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_m  = 0;
        err_m = 0;
        for (int i = 0; i < NB; i++) cnt_m[i] = 0;
    endtask

    task automatic new_payload(input int i);
        for (int a = 0; a < 3; a++) core_operands_i[i][a] = $urandom;
        core_op_i[i]    = 6'($urandom);
        core_flags_i[i] = 15'($urandom);
    endtask

    // One clock cycle: drive, check combinational and registered outputs, clock, update model.
    task automatic cycle(input logic [NB-1:0] req, input bit gnt, input bit rv,
                         input int rtag, output logic [NB-1:0] gnt_seen);
        int win;
        logic [NB-1:0] exp_gnt;
        logic [NB-1:0] exp_rv;
        bit exp_busy;
        core_req_i   = req;
        fpu_gnt_i    = gnt;
        fpu_rvalid_i = rv;
        fpu_rtag_i   = 2'(rtag);
        fpu_rdata_i  = $urandom;
        fpu_rflags_i = 5'($urandom);
        #1;
        win = -1;
        for (int k = 0; k < NB; k++) begin
            int j;
            j = (rr_m + k) % NB;
            if (win < 0 && req[j] && cnt_m[j] < MAXO) win = j;
        end
        exp_gnt  = (win >= 0 && gnt) ? NB'(1 << win) : '0;
        exp_rv   = rv ? NB'(1 << rtag) : '0;
        exp_busy = 0;
        for (int i = 0; i < NB; i++) if (cnt_m[i] != 0) exp_busy = 1;
        gnt_seen = core_gnt_o;
        chk("core_gnt", 128'(core_gnt_o), 128'(exp_gnt));
        chk("fpu_req", 128'(fpu_req_o), 128'(win >= 0));
        chk("rvalid", 128'(core_rvalid_o), 128'(exp_rv));
        chk("rdata", 128'(core_rdata_o), 128'(fpu_rdata_i));
        chk("rflags", 128'(core_rflags_o), 128'(fpu_rflags_i));
        chk("busy", 128'(busy_o), 128'(exp_busy));
        chk("err", 128'(err_o), 128'(err_m));
        if (win >= 0) begin
            chk("tag", 128'(fpu_tag_o), 128'(win));
            chk("operands", 128'(fpu_operands_o), 128'(core_operands_i[win]));
            chk("op_flags", 128'({fpu_op_o, fpu_flags_o}),
                128'({core_op_i[win], core_flags_i[win]}));
        end
        @(posedge clk_i);
        for (int i = 0; i < NB; i++) begin
            bit inc, dec;
            inc = (win == i) && gnt;
            dec = rv && (rtag == i);
            if (inc && !dec) cnt_m[i]++;
            else if (dec && !inc) begin
                if (cnt_m[i] == 0) err_m = 1;
                else cnt_m[i]--;
            end
        end
        if (win >= 0 && gnt) begin
            rr_m = (win + 1) % NB;
            new_payload(win);
        end
        @(negedge clk_i);
    endtask

    task automatic drain();
        logic [NB-1:0] g;
        for (int i = 0; i < NB; i++)
            while (cnt_m[i] > 0) cycle('0, 1'b0, 1'b1, i, g);
    endtask

    logic [NB-1:0] g;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_ni       = 1'b0;
        core_req_i   = '0;
        fpu_gnt_i    = 1'b0;
        fpu_rvalid_i = 1'b0;
        fpu_rtag_i   = '0;
        fpu_rdata_i  = '0;
        fpu_rflags_i = '0;
        for (int i = 0; i < NB; i++) new_payload(i);
        model_reset();
        #12;
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_gnt", 128'(core_gnt_o), 128'(0));
        chk("rst_fpu_req", 128'(fpu_req_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single issue from core 2 and its response
        cycle(4'b0100, 1'b1, 1'b0, 0, g);
        chk("t1_gnt", 128'(g), 128'(4'b0100));
        chk("t1_busy", 128'(busy_o), 128'(1));
        cycle(4'b0000, 1'b0, 1'b1, 2, g);
        chk("t1_idle", 128'(busy_o), 128'(0));

        // Three requesters served in rotation (pointer starts at 3 after t1)
        for (int n = 0; n < 6; n++) begin
            cycle(4'b1011, 1'b1, 1'b0, 0, g);
            chk("t2_order", 128'(g), 128'((n % 3 == 0) ? 4'b1000 :
                                          (n % 3 == 1) ? 4'b0001 : 4'b0010));
            if (n % 2 == 1) begin
                drain();
            end
        end
        drain();

        // FPU stall: request stays up, no grant, then one issue
        for (int n = 0; n < 5; n++) cycle(4'b0010, 1'b0, 1'b0, 0, g);
        cycle(4'b0010, 1'b1, 1'b0, 0, g);
        chk("t3_gnt", 128'(g), 128'(4'b0010));
        drain();

        // Outstanding cap on core 0
        for (int n = 0; n < MAXO; n++) cycle(4'b0001, 1'b1, 1'b0, 0, g);
        cycle(4'b0011, 1'b1, 1'b0, 0, g);
        chk("t4_blocked", 128'(g), 128'(4'b0010));
        cycle(4'b0001, 1'b1, 1'b0, 0, g);
        chk("t4_still_blocked", 128'(g), 128'(4'b0000));
        cycle(4'b0001, 1'b0, 1'b1, 0, g);
        cycle(4'b0001, 1'b1, 1'b0, 0, g);
        chk("t4_eligible", 128'(g), 128'(4'b0001));
        drain();

        // Concurrent issue and response for core 3
        cycle(4'b1000, 1'b1, 1'b0, 0, g);
        cycle(4'b1000, 1'b1, 1'b0, 0, g);
        cycle(4'b1000, 1'b1, 1'b1, 3, g);
        chk("t5_gnt", 128'(g), 128'(4'b1000));
        cycle(4'b1000, 1'b1, 1'b0, 0, g);
        cycle(4'b1000, 1'b1, 1'b0, 0, g);
        cycle(4'b1000, 1'b1, 1'b0, 0, g);
        chk("t5_capped", 128'(g), 128'(4'b0000));
        drain();

        // Response to an idle core raises the sticky error
        cycle(4'b0000, 1'b0, 1'b1, 1, g);
        cycle(4'b0110, 1'b1, 1'b0, 0, g);
        chk("t6_err", 128'(err_o), 128'(1));

        // Randomized traffic; responses only for cores with ops in flight
        for (int n = 0; n < 400; n++) begin
            logic [NB-1:0] req;
            bit rv;
            int rt;
            int live [$];
            req = NB'($urandom);
            live.delete();
            for (int i = 0; i < NB; i++) if (cnt_m[i] > 0) live.push_back(i);
            rv = (live.size() > 0) && ($urandom_range(0, 2) != 0);
            rt = rv ? live[$urandom_range(0, live.size() - 1)] : int'($urandom_range(0, NB - 1));
            cycle(req, ($urandom_range(0, 3) != 0), rv, rt, g);
        end

        // Asynchronous reset in the middle of a burst
        cycle(4'b1111, 1'b1, 1'b0, 0, g);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_busy", 128'(busy_o), 128'(0));
        chk("rst_mid_err", 128'(err_o), 128'(0));
        chk("rst_mid_gnt", 128'(core_gnt_o), 128'(4'b0001));
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(4'b1110, 1'b1, 1'b0, 0, g);
        chk("rst_rr", 128'(g), 128'(4'b0010));
        cycle(4'b0000, 1'b0, 1'b1, 1, g);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
